// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch sequencer.
// FSM states, the FIFO entry bundle and the fetch word size.
package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic misaligned(
    input logic [31:0] adr
  );
    return adr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries; DEPTH is a power of two.
// Ports: push/pop/flush in, din in, full/empty/head out (head zero when empty).
module fetch_fifo
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only visible through
  // head, which is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, fills a prefetch
// FIFO from combinational imem data and hands {pc, inst} to decode.
// Ports: i_run/i_redirect/i_redirect_pc control, o_imem_adr/i_imem_dat
// memory side, o_valid/o_inst/o_pc/i_ready decode side, o_fault/o_fault_pc trap.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_imem_adr,
  input  logic [31:0] i_imem_dat,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  output logic        o_fault,
  output logic [31:0] o_fault_pc
);

  localparam logic [31:0] PC_LIMIT =
    32'(MEM_WORDS * WORD_BYTES);

  state_t       state;
  state_t       next_state;
  logic [31:0]  fetch_pc;
  logic [31:0]  fault_pc;
  logic         redirect;
  logic         push;
  logic         pop;
  logic         flush;
  logic         full;
  logic         empty;
  logic         trap_align;
  logic         trap_range;
  fetch_entry_t din;
  fetch_entry_t head;

  // A redirect is dead once trapped; only reset leaves FAULT.
  assign redirect = i_redirect && (state != S_FAULT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_FETCH: begin
        if (trap_align || trap_range)
          next_state = S_FAULT;
        else if (i_run)
          next_state = S_FETCH;
        else
          next_state = S_IDLE;
      end
      default: next_state = S_FAULT;
    endcase
  end

  // Push is allowed into a full FIFO when the head leaves
  // the same cycle. The range check only fires on a push
  // that would actually happen.
  always_comb begin
    flush      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    trap_align = 1'b0;
    trap_range = 1'b0;
    unique case (1'b1)
      redirect: begin
        flush      = 1'b1;
        trap_align = misaligned(i_redirect_pc);
      end
      default: begin
        pop = !empty && i_ready;
        if (state == S_FETCH && (!full || pop)) begin
          trap_range = fetch_pc >= PC_LIMIT;
          push       = !trap_range;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      fetch_pc <= RESET_PC;
    else if (flush)
      fetch_pc <= i_redirect_pc;
    else if (push)
      fetch_pc <= fetch_pc + 32'(WORD_BYTES);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      fault_pc <= '0;
    else if (trap_align)
      fault_pc <= i_redirect_pc;
    else if (trap_range)
      fault_pc <= fetch_pc;
  end

  assign din.pc   = fetch_pc;
  assign din.inst = i_imem_dat;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign o_imem_adr = fetch_pc;
  assign o_valid    = !empty;
  assign o_inst     = head.inst;
  assign o_pc       = head.pc;
  assign o_fault    = state == S_FAULT;
  assign o_fault_pc = fault_pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: the expected program-order
// stream is queued on reset/redirect, a monitor checks every accept.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_run;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_imem_adr;
  logic [31:0] i_imem_dat;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        i_ready;
  logic        o_fault;
  logic [31:0] o_fault_pc;

  logic [31:0] mem [64];
  logic [63:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign i_imem_dat = mem[o_imem_adr[7:2]];

  imem_fetch_ctrl dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_run         (i_run),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_adr    (o_imem_adr),
    .i_imem_dat    (i_imem_dat),
    .o_valid       (o_valid),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .i_ready       (i_ready),
    .o_fault       (o_fault),
    .o_fault_pc    (o_fault_pc)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  // Sequential program order from start to the end of memory.
  task automatic load_stream(input logic [31:0] start);
    exp_q.delete();
    for (int a = int'(start); a < 256; a += 4)
      exp_q.push_back({32'(a), mem[a / 4]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen at negedge is taken at the next edge.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!i_rst && o_valid && i_ready && !i_redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept_unexpected: got pc %h, expected none",
                   o_pc);
        end else begin
          e = exp_q.pop_front();
          chk("accept_pc", o_pc, e[63:32]);
          chk("accept_inst", o_inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] hold;
    logic [31:0] adr3;
    logic [31:0] tgt;
    int since;
    bit seen;

    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom() & 32'hFFFF_FF00) | 32'(i);
    i_rst = 1'b1;
    i_run = 1'b0;
    i_ready = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    tgt = '0;
    repeat (2) tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_fault_pc", o_fault_pc, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_adr", o_imem_adr, 32'd0);

    // First fetch latency and back-to-back throughput.
    i_rst = 1'b0;
    load_stream(32'h0);
    i_run = 1'b1;
    i_ready = 1'b1;
    tick();
    chk("lat_valid_c1", 32'(o_valid), 32'd0);
    chk("lat_adr_c1", o_imem_adr, 32'd0);
    tick();
    chk("lat_valid_c2", 32'(o_valid), 32'd1);
    chk("lat_pc_c2", o_pc, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_valid", 32'(o_valid), 32'd1);
    end

    // Back-pressure: head stable, FIFO fills, PC stalls.
    i_ready = 1'b0;
    hold = o_pc;
    adr3 = '0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("stall_pc", o_pc, hold);
      chk("stall_valid", 32'(o_valid), 32'd1);
      if (i == 3) adr3 = o_imem_adr;
    end
    chk("stall_adr", o_imem_adr, adr3);
    chk("stall_adr_full", o_imem_adr, hold + 32'd8);
    i_ready = 1'b1;
    repeat (6) tick();

    // Redirect with a full FIFO.
    i_ready = 1'b0;
    repeat (3) tick();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h20;
    tick();
    i_redirect = 1'b0;
    load_stream(32'h20);
    chk("redir_valid", 32'(o_valid), 32'd0);
    chk("redir_adr", o_imem_adr, 32'h20);
    tick();
    chk("redir_valid2", 32'(o_valid), 32'd1);
    chk("redir_pc", o_pc, 32'h20);
    chk("redir_inst", o_inst, mem[8]);
    i_ready = 1'b1;

    // Random run/ready/redirect, kept short of the memory end.
    since = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (i_redirect) begin
        load_stream(tgt);
        since = 0;
      end
      i_redirect = 1'b0;
      i_run = $urandom_range(0, 9) < 8;
      i_ready = $urandom_range(0, 9) < 7;
      since++;
      if (since >= 20 || $urandom_range(0, 7) == 0) begin
        tgt = 32'($urandom_range(0, 32)) * 32'd4;
        i_redirect_pc = tgt;
        i_redirect = 1'b1;
      end
    end
    tick();
    if (i_redirect) load_stream(tgt);
    i_redirect = 1'b0;

    // Run off the end of memory.
    i_run = 1'b1;
    i_ready = 1'b1;
    i_redirect = 1'b1;
    i_redirect_pc = 32'hF0;
    tick();
    i_redirect = 1'b0;
    load_stream(32'hF0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = o_fault;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL range_timeout: got no fault, expected fault");
    end
    repeat (4) tick();
    chk("range_fault", 32'(o_fault), 32'd1);
    chk("range_fault_pc", o_fault_pc, 32'h100);
    chk("range_drained", 32'(exp_q.size()), 32'd0);
    chk("range_valid", 32'(o_valid), 32'd0);
    chk("range_adr", o_imem_adr, 32'h100);

    // Async reset mid-stream.
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    load_stream(32'h0);
    repeat (6) tick();
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_adr", o_imem_adr, 32'd0);
    chk("arst_fault", 32'(o_fault), 32'd0);
    tick();
    i_rst = 1'b0;
    load_stream(32'h0);
    repeat (6) tick();

    // Misaligned redirect traps for good.
    i_redirect = 1'b1;
    i_redirect_pc = 32'h22;
    tick();
    i_redirect = 1'b0;
    exp_q.delete();
    chk("mis_fault", 32'(o_fault), 32'd1);
    chk("mis_fault_pc", o_fault_pc, 32'h22);
    chk("mis_valid", 32'(o_valid), 32'd0);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h40;
    tick();
    i_redirect = 1'b0;
    repeat (4) tick();
    chk("mis_hold_valid", 32'(o_valid), 32'd0);
    chk("mis_hold_adr", o_imem_adr, 32'h22);
    chk("mis_hold_fault", 32'(o_fault), 32'd1);
    chk("mis_hold_fault_pc", o_fault_pc, 32'h22);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
